adder16_arbiter: RTL and testbench

ADDER16_ARBITER -- requirements
Module: adder16_arbiter

---
 rtl/adder16_arbiter_pkg.sv | 7 +
 rtl/adder16_arbiter_adder16.sv | 13 +
 rtl/adder16_arbiter.sv | 95 +++++++++
 tb/tb_adder16_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/adder16_arbiter_pkg.sv
// adder16_arbiter_pkg: shared widths and FSM states for the adder arbiter
package adder16_arbiter_pkg;
  localparam int DW = 16;
  localparam int NUM_REQ = 4;
  localparam int PTR_W = 2;
  typedef enum logic [1:0] {IDLE, ADD, RESP} state_e;
endpackage

// File: rtl/adder16_arbiter_adder16.sv
// adder16: 16-bit modular ripple adder, carry-out is never formed
module adder16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o
);
  logic [15:0] c;
  assign c[0] = 1'b0;
  for (genvar i = 1; i < 16; i++) begin : g_carry
    assign c[i] = (a_i[i-1] & b_i[i-1]) | (c[i-1] & (a_i[i-1] ^ b_i[i-1]));
  end
  assign sum_o = a_i ^ b_i ^ c;
endmodule

// File: rtl/adder16_arbiter.sv
// adder16_arbiter: round-robin sharing of one ripple adder among four requesters
module adder16_arbiter
  import adder16_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DW = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_a,
  input  logic [NUM_REQ*DW-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [PTR_W-1:0]      rsp_id,
  output logic [DW-1:0]         rsp_sum,
  output logic                  busy,
  output logic [15:0]           done_cnt
);
  state_e state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, id_q, id_d, win, idx;
  logic [DW-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, sum_w;
  logic [15:0] cnt_q, cnt_d;
  logic found;

  adder16 u_add (.a_i(a_q), .b_i(b_q), .sum_o(sum_w));

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    req_ready = '0;
    found = 1'b0;
    win = ptr_q;
    idx = ptr_q;
    // first valid requester at or after ptr, wrapping modulo NUM_REQ
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr_q + PTR_W'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
    case (state_q)
      IDLE: if (found) begin
        req_ready[win] = 1'b1;
        a_d = req_a[DW*win +: DW];
        b_d = req_b[DW*win +: DW];
        id_d = win;
        ptr_d = win + 1'b1;
        state_d = ADD;
      end
      ADD: begin
        sum_d = sum_w;
        state_d = RESP;
      end
      RESP: if (rsp_ready) begin
        cnt_d = cnt_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

  assign rsp_valid = state_q == RESP;
  assign rsp_id = id_q;
  assign rsp_sum = sum_q;
  assign busy = state_q != IDLE;
  assign done_cnt = cnt_q;
endmodule

// File: tb/tb_adder16_arbiter.sv
// tb_adder16_arbiter: directed vectors with hand-computed results for adder16_arbiter
module tb_adder16_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req_valid = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [3:0] req_ready;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [1:0] rsp_id;
  logic [15:0] rsp_sum;
  logic busy;
  logic [15:0] done_cnt;
  int n_chk = 0;
  int n_ok = 0;

  adder16_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_cnt, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_id", rsp_id, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("idle_noreq_ready", req_ready, 4'b0000);
    tick;
    chk("idle_noreq_busy", busy, 0);

    // single request on requester 0
    req_valid = 4'b0001;
    req_a[15:0] = 16'h1234;
    req_b[15:0] = 16'h0101;
    #1;
    chk("single_grant", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    #1;
    chk("single_add_ready", req_ready, 4'b0000);
    chk("single_add_busy", busy, 1);
    chk("single_add_rspv", rsp_valid, 0);
    tick;
    chk("single_rspv", rsp_valid, 1);
    chk("single_sum", rsp_sum, 16'h1335);
    chk("single_id", rsp_id, 0);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("single_done", done_cnt, 1);
    chk("single_idle_rspv", rsp_valid, 0);

    // overflow cases, ptr now at 1 then 2
    req_valid = 4'b0010;
    req_a[31:16] = 16'hFFFF;
    req_b[31:16] = 16'h0001;
    #1;
    chk("ovf1_grant", req_ready, 4'b0010);
    tick;
    req_valid = '0;
    tick;
    chk("ovf1_sum", rsp_sum, 16'h0000);
    chk("ovf1_id", rsp_id, 1);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    req_a[47:32] = 16'h8000;
    req_b[47:32] = 16'h8000;
    #1;
    chk("ovf2_grant", req_ready, 4'b0100);
    tick;
    req_valid = '0;
    tick;
    chk("ovf2_sum", rsp_sum, 16'h0000);
    chk("ovf2_id", rsp_id, 2);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("ovf_done", done_cnt, 3);

    // contention after reset: order 0,1,2,3,0, one grant per 3 cycles
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req_a = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
    req_b = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk($sformatf("cont_grant%0d", g), req_ready, 4'b0001 << (g % 4));
      tick;
      if (g == 4) req_valid = '0;
      chk($sformatf("cont_add_ready%0d", g), req_ready, 4'b0000);
      tick;
      chk($sformatf("cont_rspv%0d", g), rsp_valid, 1);
      chk($sformatf("cont_id%0d", g), rsp_id, g % 4);
      chk($sformatf("cont_sum%0d", g), rsp_sum, 16'h1001 * ((g % 4) + 1));
      tick;
    end
    chk("cont_done", done_cnt, 5);

    // backpressure: ptr at 1, others keep requesting while RESP stalls
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("bp_grant", req_ready, 4'b0010);
    tick;
    tick;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_rspv%0d", c), rsp_valid, 1);
      chk($sformatf("bp_sum%0d", c), rsp_sum, 16'h2002);
      chk($sformatf("bp_id%0d", c), rsp_id, 1);
      chk($sformatf("bp_ready%0d", c), req_ready, 4'b0000);
      tick;
    end
    chk("bp_done_hold", done_cnt, 5);
    rsp_ready = 1'b1;
    tick;
    req_valid = '0;
    rsp_ready = 1'b0;
    chk("bp_done", done_cnt, 6);
    tick;
    chk("bp_no_extra", done_cnt, 6);

    // reset mid-RESP, ptr at 2 so requester 0 wins
    req_valid = 4'b0001;
    tick;
    req_valid = '0;
    tick;
    chk("mid_rspv_pre", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rspv", rsp_valid, 0);
    chk("mid_done", done_cnt, 0);
    chk("mid_busy", busy, 0);
    chk("mid_sum", rsp_sum, 0);
    tick;
    rst_n = 1'b1;
    req_valid = 4'b1010;
    #1;
    chk("mid_regrant", req_ready, 4'b0010);
    tick;
    req_valid = '0;
    tick;
    chk("mid_id", rsp_id, 1);
    chk("mid_sum2", rsp_sum, 16'h2002);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("mid_done2", done_cnt, 1);

    // counter wrap from 0xFFFF
    req_valid = 4'b0001;
    tick;
    req_valid = '0;
    tick;
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    #1;
    chk("wrap_pre", done_cnt, 16'hFFFF);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("wrap_done", done_cnt, 16'h0000);
    chk("wrap_idle", busy, 0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
